// File: rtl/warp_fetch_unit_if.sv
// rtl/warp_fetch_unit_if.sv - warp control, icache read port and tagged instruction bundle
// FETCH_PERF_CNT_EN adds the perf_issue_cnt/perf_stall_cnt signals.
interface warp_fetch_unit_if #(
  parameter int NUM_WARPS = 8,
  parameter int WID       = 3,
  parameter int ADDR      = 10,
  parameter int DATA      = 32
);
  logic                 launch_valid;
  logic [WID-1:0]       launch_wid;
  logic [ADDR-1:0]      launch_pc;
  logic                 exit_valid;
  logic [WID-1:0]       exit_wid;
  logic                 redirect_valid;
  logic [WID-1:0]       redirect_wid;
  logic [ADDR-1:0]      redirect_pc;
  logic [NUM_WARPS-1:0] ibuf_pop;
  logic [ADDR-1:0]      icache_addr;
  logic [DATA-1:0]      icache_rdata;
  logic                 inst_valid;
  logic [WID-1:0]       inst_wid;
  logic [ADDR-1:0]      inst_pc;
  logic [DATA-1:0]      inst_data;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]          perf_issue_cnt;
  logic [31:0]          perf_stall_cnt;
`endif

  modport master (
    output launch_valid, launch_wid, launch_pc, exit_valid, exit_wid,
           redirect_valid, redirect_wid, redirect_pc, ibuf_pop, icache_rdata,
    input  icache_addr, inst_valid, inst_wid, inst_pc, inst_data
`ifdef FETCH_PERF_CNT_EN
    , input perf_issue_cnt, perf_stall_cnt
`endif
  );

  modport slave (
    input  launch_valid, launch_wid, launch_pc, exit_valid, exit_wid,
           redirect_valid, redirect_wid, redirect_pc, ibuf_pop, icache_rdata,
    output icache_addr, inst_valid, inst_wid, inst_pc, inst_data
`ifdef FETCH_PERF_CNT_EN
    , output perf_issue_cnt, perf_stall_cnt
`endif
  );
endinterface

// File: rtl/warp_fetch_unit.sv
// rtl/warp_fetch_unit.sv - round-robin per-warp fetch ahead of the icache read port
// FETCH_PERF_CNT_EN adds issue/stall counters.
module warp_fetch_unit #(
  parameter int NUM_WARPS = 8,
  parameter int WID       = 3,
  parameter int ADDR      = 10,
  parameter int DATA      = 32,
  parameter int CREDITS   = 2
) (
  input logic              clk,
  input logic              rst_n,
  warp_fetch_unit_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = CW + 2;

  logic [NUM_WARPS-1:0] active;
  logic [ADDR-1:0]      pc         [NUM_WARPS];
  logic [CW-1:0]        credit     [NUM_WARPS];
  logic [CW-1:0]        credit_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] hit_launch, hit_exit, hit_redir, kill, eligible;
  logic [WID-1:0]       rr_ptr, grant_wid, idx;
  logic                 grant;
  logic [ADDR-1:0]      last_addr;
  logic                 s1_valid, s2_valid;
  logic [WID-1:0]       s1_wid, s2_wid;
  logic [ADDR-1:0]      s1_pc, s2_pc;
  logic [SW-1:0]        csum;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      hit_launch[w] = bus.launch_valid   && (bus.launch_wid   == WID'(w));
      hit_exit[w]   = bus.exit_valid     && (bus.exit_wid     == WID'(w));
      hit_redir[w]  = bus.redirect_valid && (bus.redirect_wid == WID'(w));
      kill[w]       = hit_launch[w] | hit_exit[w] | hit_redir[w];
      eligible[w]   = active[w] && (credit[w] != '0) && !kill[w];
    end
  end

  // Search starts one past the last grant so every warp gets a turn.
  always_comb begin
    grant     = 1'b0;
    grant_wid = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = rr_ptr + WID'(i);
      if (!grant && eligible[idx]) begin
        grant     = 1'b1;
        grant_wid = idx;
      end
    end
  end

  // Killed in-flight fetches never land in the IBuffer, so their slots come back.
  always_comb begin
    csum = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      csum = SW'(credit[w]) + SW'(bus.ibuf_pop[w])
           + SW'(s1_valid && (s1_wid == WID'(w)) && kill[w])
           + SW'(s2_valid && (s2_wid == WID'(w)) && kill[w]);
      if (grant && (grant_wid == WID'(w)))
        csum = csum - SW'(1);
      credit_nxt[w] = (csum > SW'(CREDITS)) ? CW'(CREDITS) : csum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      rr_ptr    <= WID'(NUM_WARPS - 1);
      last_addr <= '0;
      s1_valid  <= 1'b0;
      s1_wid    <= '0;
      s1_pc     <= '0;
      s2_valid  <= 1'b0;
      s2_wid    <= '0;
      s2_pc     <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc[w]     <= '0;
        credit[w] <= CW'(CREDITS);
      end
    end else begin
      if (grant) begin
        rr_ptr    <= grant_wid;
        last_addr <= pc[grant_wid];
      end
      s1_valid <= grant;
      s1_wid   <= grant_wid;
      s1_pc    <= pc[grant_wid];
      s2_valid <= s1_valid && !kill[s1_wid];
      s2_wid   <= s1_wid;
      s2_pc    <= s1_pc;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (hit_launch[w]) begin
          active[w] <= 1'b1;
          pc[w]     <= bus.launch_pc;
          credit[w] <= CW'(CREDITS);
        end else begin
          credit[w] <= credit_nxt[w];
          if (hit_exit[w])
            active[w] <= 1'b0;
          else if (hit_redir[w])
            pc[w] <= bus.redirect_pc;
          else if (grant && (grant_wid == WID'(w)))
            pc[w] <= pc[w] + ADDR'(1);
        end
      end
    end
  end

  assign bus.icache_addr = grant ? pc[grant_wid] : last_addr;
  assign bus.inst_valid  = s2_valid && !kill[s2_wid];
  assign bus.inst_wid    = s2_wid;
  assign bus.inst_pc     = s2_pc;
  assign bus.inst_data   = bus.inst_valid ? bus.icache_rdata : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] issue_cnt, stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      issue_cnt <= issue_cnt + 32'(grant);
      stall_cnt <= stall_cnt + 32'((|active) && !grant);
    end
  end
  assign bus.perf_issue_cnt = issue_cnt;
  assign bus.perf_stall_cnt = stall_cnt;
`endif

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pop_chk
    a_pop_at_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.ibuf_pop[w] && (credit[w] == CW'(CREDITS))))
      else $error("ibuf_pop on warp %0d with full credit", w);
  end
endmodule
